// File: rtl/char_motion_ctrl_pkg.sv
// char_motion_ctrl_pkg: shared game constants, character state codes and motion modes
package char_motion_ctrl_pkg;
   localparam logic [3:0] S_IDLE                = 4'd0;
   localparam logic [3:0] S_LEFT                = 4'd1;
   localparam logic [3:0] S_RIGHT               = 4'd2;
   localparam logic [3:0] S_ATTACK_WINDUP       = 4'd3;
   localparam logic [3:0] S_ATTACK_ACTIVE       = 4'd4;
   localparam logic [3:0] S_ATTACK_RECOVERY     = 4'd5;
   localparam logic [3:0] S_ATTACK_DIR_WINDUP   = 4'd6;
   localparam logic [3:0] S_ATTACK_DIR_ACTIVE   = 4'd7;
   localparam logic [3:0] S_ATTACK_DIR_RECOVERY = 4'd8;
   typedef enum logic {MODE_MOVE = 1'b0, MODE_KB = 1'b1} mode_t;
   localparam int SCR_MIN_X      = 40;
   localparam int SCR_MAX_X      = 600;
   localparam int SCR_CHAR_WIDTH = 128;
endpackage

// File: rtl/char_motion_ctrl_x_clamp.sv
// char_motion_ctrl_x_clamp: saturating add/sub of a step, then clamp into [i_lo, i_hi]
module char_motion_ctrl_x_clamp #(
   parameter int W = 11
) (
   input  logic [W-1:0] i_x,
   input  logic [W-1:0] i_step,
   input  logic         i_sub,
   input  logic [W-1:0] i_lo,
   input  logic [W-1:0] i_hi,
   output logic [W-1:0] o_x
);
   logic [W-1:0] w_v;
   assign w_v = i_sub ? ((i_x >= i_step) ? i_x - i_step : '0) : i_x + i_step;
   assign o_x = (w_v < i_lo) ? i_lo : (w_v > i_hi) ? i_hi : w_v;
endmodule

// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: frame-tick character x motion with wall/opponent limits and timed knockback
module char_motion_ctrl
   import char_motion_ctrl_pkg::*;
#(
   parameter int COORD_W    = 10,
   parameter int INIT_X     = 40,
   parameter int INIT_Y     = 200,
   parameter int MIN_X      = SCR_MIN_X,
   parameter int MAX_X      = SCR_MAX_X,
   parameter int CHAR_WIDTH = SCR_CHAR_WIDTH,
   parameter int STEP_FWD   = 3,
   parameter int STEP_BACK  = 2,
   parameter int KB_STEP    = 4,
   parameter int KB_FRAMES  = 8,
   parameter bit FACE_LEFT  = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic [3:0]         state,
   input  logic [COORD_W-1:0] opp_x,
   input  logic               hit_in,
   output logic [COORD_W-1:0] char_x,
   output logic [COORD_W-1:0] char_y,
   output logic               kb_active,
   output logic               at_wall
);
   localparam int XW = COORD_W + 1;
   localparam int CW = $clog2(KB_FRAMES + 1);
   localparam logic [XW-1:0] WALL_LO = XW'(MIN_X);
   localparam logic [XW-1:0] WALL_HI = XW'(MAX_X - CHAR_WIDTH);
   localparam logic [XW-1:0] WIDTH   = XW'(CHAR_WIDTH);
   localparam logic          WALL_INIT = (INIT_X == MIN_X) || (INIT_X == MAX_X - CHAR_WIDTH);
   mode_t               r_mode, w_mode_nx;
   logic [CW-1:0]       r_cnt, w_cnt_nx;
   logic [COORD_W-1:0]  r_x, w_x_nx;
   logic                r_wall, w_wall_nx;
   logic [XW-1:0]       w_x, w_opp, w_opp_plus, w_opp_minus, w_left_lim, w_right_lim;
   logic [XW-1:0]       w_step, w_lo, w_hi, w_clamped;
   logic                w_kb, w_left, w_right, w_walk, w_sub;
   assign w_x         = {1'b0, r_x};
   assign w_opp       = {1'b0, opp_x};
   assign w_opp_plus  = w_opp + WIDTH;
   assign w_opp_minus = (w_opp >= WIDTH) ? w_opp - WIDTH : '0;
   assign w_left_lim  = (FACE_LEFT && w_opp_plus > WALL_LO) ? w_opp_plus : WALL_LO;
   assign w_right_lim = (!FACE_LEFT && w_opp_minus < WALL_HI) ? w_opp_minus : WALL_HI;
   assign w_kb        = (r_mode == MODE_KB);
   assign w_left      = (state == S_LEFT);
   assign w_right     = (state == S_RIGHT);
   // Only step when strictly inside the limit, so an overlap is never pushed further in
   assign w_walk      = (w_left && w_x > w_left_lim) || (w_right && w_x < w_right_lim);
   assign w_sub       = w_kb ? !FACE_LEFT : w_left;
   assign w_step      = w_kb ? XW'(KB_STEP) : (w_left != FACE_LEFT) ? XW'(STEP_BACK) : XW'(STEP_FWD);
   assign w_lo        = w_kb ? WALL_LO : w_left ? w_left_lim : '0;
   assign w_hi        = w_kb ? WALL_HI : w_left ? '1 : w_right_lim;
   char_motion_ctrl_x_clamp #(.W(XW)) u_clamp (
      .i_x    (w_x),
      .i_step (w_step),
      .i_sub  (w_sub),
      .i_lo   (w_lo),
      .i_hi   (w_hi),
      .o_x    (w_clamped)
   );
   always_comb begin
      w_mode_nx = r_mode;
      w_cnt_nx  = r_cnt;
      w_x_nx    = r_x;
      if (hit_in) begin
         w_mode_nx = MODE_KB;
         w_cnt_nx  = CW'(KB_FRAMES);
      end else if (frame_tick && w_kb) begin
         w_x_nx    = COORD_W'(w_clamped);
         w_cnt_nx  = r_cnt - CW'(1);
         w_mode_nx = (r_cnt == CW'(1)) ? MODE_MOVE : MODE_KB;
      end else if (frame_tick && w_walk) begin
         w_x_nx = COORD_W'(w_clamped);
      end
      w_wall_nx = ({1'b0, w_x_nx} == WALL_LO) || ({1'b0, w_x_nx} == WALL_HI);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode <= MODE_MOVE;
         r_cnt  <= '0;
         r_x    <= COORD_W'(INIT_X);
         r_wall <= WALL_INIT;
      end else begin
         r_mode <= w_mode_nx;
         r_cnt  <= w_cnt_nx;
         r_x    <= w_x_nx;
         r_wall <= w_wall_nx;
      end
   end
   assign char_x    = r_x;
   assign char_y    = COORD_W'(INIT_Y);
   assign kb_active = w_kb;
   assign at_wall   = r_wall;
endmodule
